// File: rtl/tpg_pkg.sv
// tpg_pkg: shared types, bar colour tables and helpers for the test pattern generator
package tpg_pkg;
  typedef enum logic [2:0] {
    TPG_SOLID   = 3'd0,
    TPG_GRID    = 3'd1,
    TPG_CHECKER = 3'd2,
    TPG_BARS    = 3'd3,
    TPG_RAMP    = 3'd4
  } tpg_mode_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tpg_state_e;
  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0] BAR_RGB332 [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
  localparam logic [23:0] BAR_RGB888 [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  function automatic logic [23:0] bar_color(input logic [2:0] idx, input int cw);
    return cw == 8 ? {16'h0, BAR_RGB332[idx]} : BAR_RGB888[idx];
  endfunction
endpackage

// File: rtl/tpg_raster_counter.sv
// tpg_raster_counter: raster x/y/address/bar-index counters for the next pixel to load
module tpg_raster_counter #(
  parameter int W     = 16,
  parameter int H     = 8,
  parameter int AW    = 7,
  parameter int BAR_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  output logic [12:0]   x,
  output logic [12:0]   y,
  output logic [AW-1:0] addr,
  output logic [2:0]    bar,
  output logic          last
);
  // Too narrow a frame for 8 bars puts every column in the last bar
  localparam logic [2:0] BAR0 = BAR_W == 0 ? 3'd7 : 3'd0;
  logic [12:0] bx;
  logic row_end, bar_step;
  assign row_end  = x == 13'(W - 1);
  assign last     = row_end && y == 13'(H - 1);
  assign bar_step = bar != 3'd7 && bx == 13'(BAR_W - 1);
  // Advancing past the last pixel wraps everything so the next frame starts at 0
  always_ff @(posedge clk)
    if (!rst_n || (adv && last)) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
      bar  <= BAR0;
      bx   <= '0;
    end else if (adv) begin
      x    <= row_end ? '0 : x + 13'd1;
      y    <= row_end ? y + 13'd1 : y;
      addr <= addr + AW'(1);
      bx   <= row_end || bar_step ? '0 : bx + 13'd1;
      bar  <= row_end ? BAR0 : bar_step ? bar + 3'd1 : bar;
    end
endmodule

// File: rtl/tpg_multi_pattern_writer.sv
// tpg_multi_pattern_writer: multi-mode test pattern generator writing the framebuffer over valid/ready
module tpg_multi_pattern_writer
  import tpg_pkg::*;
#(
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int SCALING_FACTOR  = 1,
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int COLOR_WIDTH     = 8,
  parameter int GRID_LOG2       = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       continuous,
  input  logic [2:0]                 mode,
  input  logic [COLOR_WIDTH-1:0]     fg_color,
  input  logic [COLOR_WIDTH-1:0]     bg_color,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [COLOR_WIDTH-1:0]     fbuf_data,
  output logic                       fbuf_wr_en,
  input  logic                       fbuf_wr_ready,
  output logic                       busy,
  output logic                       frame_done,
  output logic [15:0]                frame_count
);
  localparam int W = FRAME_WIDTH / SCALING_FACTOR;
  localparam int H = FRAME_HEIGHT / SCALING_FACTOR;
  localparam int G = GRID_LOG2;
  localparam logic [G-1:0] GMID = G'(1) << (G - 1);
  if (COLOR_WIDTH != 8 && COLOR_WIDTH != 24) begin : g_bad_cw
    $error("COLOR_WIDTH must be 8 or 24");
  end
  if ((64'd1 << FBUF_ADDR_WIDTH) < 64'(W * H)) begin : g_bad_aw
    $error("FBUF_ADDR_WIDTH too small for the frame");
  end
  tpg_state_e state, state_nx;
  logic [2:0] mode_q, mode_e;
  logic [COLOR_WIDTH-1:0] fg_q, bg_q, fg_e, bg_e, pix;
  logic [FBUF_ADDR_WIDTH-1:0] addr_c;
  logic [12:0] x, y;
  logic [2:0] bar;
  logic [23:0] ramp, barc;
  logic last, load, accept, adv, pend_last, grid_hit, relatch;
  tpg_raster_counter #(.W(W), .H(H), .AW(FBUF_ADDR_WIDTH), .BAR_W(W / 8)) u_cnt (
    .clk(clk), .rst_n(rst_n), .adv(adv), .x(x), .y(y), .addr(addr_c), .bar(bar), .last(last)
  );
  assign load       = !fbuf_wr_en || fbuf_wr_ready;
  assign accept     = fbuf_wr_en && fbuf_wr_ready;
  assign relatch    = (state == ST_IDLE && start) || (state == ST_DONE && continuous);
  // In DONE pixel 0 of the next frame is loaded straight from the inputs being latched
  assign adv        = (state == ST_RUN && load && !pend_last) || (state == ST_DONE && continuous);
  assign busy       = state != ST_IDLE;
  assign frame_done = state == ST_DONE;
  assign mode_e     = state == ST_RUN ? mode_q : mode;
  assign fg_e       = state == ST_RUN ? fg_q : fg_color;
  assign bg_e       = state == ST_RUN ? bg_q : bg_color;
  assign grid_hit   = x[G-1:0] == GMID || y[G-1:0] == GMID;
  assign ramp       = 24'(x) + 24'(y) + 24'(frame_count);
  assign barc       = bar_color(bar, COLOR_WIDTH);
  always_comb begin
    pix = mode_e == TPG_GRID    ? (grid_hit ? fg_e : bg_e) :
          mode_e == TPG_CHECKER ? ((x[G] ^ y[G]) ? fg_e : bg_e) :
          mode_e == TPG_BARS    ? COLOR_WIDTH'(barc) :
          mode_e == TPG_RAMP    ? COLOR_WIDTH'(ramp) : bg_e;
    state_nx = state == ST_IDLE ? (start ? ST_RUN : ST_IDLE) :
               state == ST_RUN  ? (accept && pend_last ? ST_DONE : ST_RUN) :
               continuous       ? ST_RUN : ST_IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state       <= ST_IDLE;
      mode_q      <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      fbuf_wr_en  <= 1'b0;
      fbuf_addr   <= '0;
      fbuf_data   <= '0;
      frame_count <= '0;
      pend_last   <= 1'b0;
    end else begin
      state <= state_nx;
      if (relatch) begin
        mode_q <= mode;
        fg_q   <= fg_color;
        bg_q   <= bg_color;
      end
      if (adv) begin
        fbuf_wr_en <= 1'b1;
        fbuf_addr  <= addr_c;
        fbuf_data  <= pix;
      end else if (accept) fbuf_wr_en <= 1'b0;
      // pend_last marks the output register holding the final pixel of the frame
      if (adv && last) pend_last <= 1'b1;
      else if (accept && pend_last) pend_last <= 1'b0;
      if (state == ST_RUN && accept && pend_last) frame_count <= frame_count + 16'd1;
    end
endmodule
